// File: rtl/multiplexer_4_to_1_arbitrated.sv
// Four-lane valid/ready merge stage with round-robin arbitration.
// The selected word is held in a registered output together with its source lane index.
module multiplexer_4_to_1_arbitrated #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         select_lines,
  input  logic               out_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       grant_found;
  logic       load_en;
  logic       transfer;

  assign out_valid = (state == FULL);
  assign load_en   = ~out_valid | out_ready;

  // Search starts one past the last accepted lane, so a lane can never be granted twice in a row
  // while another lane is waiting.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise paths that skip an
    // assignment infer a latch.
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && grant_found) in_ready[grant_idx] = 1'b1;
  end

  // in_ready is only ever set for a granted lane, and a lane is granted only when its valid is high.
  assign transfer = |in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      out_data     <= '0;
      select_lines <= 2'b00;
      last_grant   <= 2'b11;
    end else if (transfer) begin
      state        <= FULL;
      out_data     <= in_data[grant_idx*WIDTH +: WIDTH];
      select_lines <= grant_idx;
      last_grant   <= grant_idx;
    end else if (out_ready) begin
      state        <= EMPTY;
    end
  end

endmodule

// File: tb/tb_multiplexer_4_to_1_arbitrated.sv
// Directed bench for multiplexer_4_to_1_arbitrated: behavioural round-robin model
// plus a scoreboard of accepted words, checked on the falling clock edge.
module tb_multiplexer_4_to_1_arbitrated;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } entry_t;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   select_lines;
  logic         out_ready;

  logic [W-1:0] lane_word [4];
  entry_t       sb[$];
  logic         m_valid;
  logic [1:0]   m_last;
  int           passed;
  int           total;

  assign in_data = {lane_word[3], lane_word[2], lane_word[1], lane_word[0]};

  multiplexer_4_to_1_arbitrated #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .select_lines(select_lines),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // First valid lane in the order (last+1, last+2, ...) mod 4; -1 if none.
  function automatic int model_grant(input logic [3:0] v, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int lane;
      lane = (int'(last) + k) % 4;
      if (v[lane]) return lane;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model, wait past the rising edge.
  task automatic cycle(input logic r, input logic [3:0] v, input logic ordy);
    int     g;
    logic [3:0] exp_rdy;
    entry_t e;
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        total++;
        $error("FAIL scoreboard: observed empty expected held word");
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("select_lines", 32'(select_lines), 32'(sb[0].sel));
      end
    end
    g = model_grant(v, m_last);
    exp_rdy = 4'b0000;
    if (!r && (!m_valid || ordy) && g >= 0) exp_rdy = 4'(1) << g;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      sb.delete();
      m_valid = 1'b0;
      m_last  = 2'b11;
    end else begin
      if (m_valid && ordy) begin
        void'(sb.pop_front());
        m_valid = 1'b0;
      end
      if (exp_rdy != 4'b0000) begin
        e.data = lane_word[g];
        e.sel  = 2'(g);
        sb.push_back(e);
        m_valid = 1'b1;
        m_last  = 2'(g);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_valid = 1'b0;
    m_last  = 2'b11;
    for (int i = 0; i < 4; i++) lane_word[i] = 8'h00;
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for two cycles with every lane offering.
    cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset select_lines", 32'(select_lines), 32'h0);
    // First cycle after release: lane 0 has priority; nothing offered is left over.
    cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Single lane.
    lane_word[2] = 8'hA5;
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    check("single out_data", 32'(out_data), 32'hA5);
    check("single select", 32'(select_lines), 32'h2);
    cycle(1'b0, 4'b0000, 1'b1);

    // Full contention: rotation 0,1,2,3,... with no bubbles. last_grant is 2 here, so start lane 3
    // and run until lane 0 leads; a reset re-centres priority on lane 0 first.
    cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) lane_word[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Backpressure with 8'h11 held from lane 1, lanes 0 and 3 waiting.
    cycle(1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1001, 1'b0);
      check("stall data", 32'(out_data), 32'h11);
      check("stall select", 32'(select_lines), 32'h1);
    end
    cycle(1'b0, 4'b1001, 1'b1);
    check("after stall select", 32'(select_lines), 32'h3);
    cycle(1'b0, 4'b0001, 1'b1);
    check("after stall select 2", 32'(select_lines), 32'h0);
    cycle(1'b0, 4'b0000, 1'b1);

    // Sparse rotation with idle gaps.
    lane_word[3] = 8'h3C;
    lane_word[0] = 8'hC0;
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    // Idle cycles left last_grant at 3: lanes 2 and 0 both valid, lane 0 wins.
    cycle(1'b0, 4'b0101, 1'b1);
    check("sparse wrap select", 32'(select_lines), 32'h0);
    cycle(1'b0, 4'b0100, 1'b1);

    // Mid-operation reset discards the held word.
    lane_word[1] = 8'h77;
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    check("midreset select", 32'(select_lines), 32'h0);
    cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    check("post reset grant", 32'(select_lines), 32'h0);
    cycle(1'b0, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multiplexer_4_to_1_arbitrated.md
# multiplexer_4_to_1_arbitrated

Sequential 4-to-1 merge stage: collects words from four valid/ready input lanes, picks one per cycle by round-robin arbitration, and presents it on a single registered output lane. It emits the 2-bit source index on `select_lines`, so the far end can route the word back out through a 1-to-4 demultiplexer. The block is the merging side of the team's lane-routing path.

## Interface
- `WIDTH`, default 8: data width of each lane, in bits.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_valid`  input  4  bit i set: lane i offers a word.
- `in_data`  input  4*WIDTH  lane i word at `[i*WIDTH +: WIDTH]`.
- `in_ready`  output  4  bit i set: lane i word is accepted this cycle. Combinational.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  held word.
- `select_lines`  output  2  index of the lane that supplied `out_data`.
- `out_ready`  input  1  downstream accepts the held word this cycle.

## Operation
- Registered state:
  - output register: `out_valid`, `out_data`, `select_lines`.
  - `last_grant[1:0]`: index of the most recently accepted lane.
- Output-register states:
  - EMPTY (`out_valid`=0): goes to FULL when an input transfer occurs.
  - FULL (`out_valid`=1):
    - goes to EMPTY on `out_ready`=1 with no input transfer.
    - stays FULL and reloads on `out_ready`=1 with an input transfer.
    - holds all outputs unchanged on `out_ready`=0.
- Load enable: `load_en` = ~`out_valid` | `out_ready`.
- Arbitration:
  - Search order starts at lane (`last_grant`+1) mod 4 and wraps around, e.g. `last_grant`=2 gives order 3,0,1,2.
  - The first lane in that order with `in_valid` set is granted.
  - With no valid lane there is no grant.
- `in_ready[i]` = `load_en` & grant[i]; at most one bit is set.
  - `in_ready` depends combinationally on `out_ready` and `in_valid`.
  - `in_ready` never depends on `in_ready` itself.
- Transfer on lane i: `in_valid[i]` & `in_ready[i]`. On the next edge:
  - `out_data` <= lane i word.
  - `select_lines` <= i.
  - `out_valid` <= 1.
  - `last_grant` <= i.
- With no transfer, `last_grant` is unchanged. The rotation advances only on accepted words, never on idle or stalled cycles.
- Fairness: any lane holding `in_valid` is accepted within 4 transfers.
- Upstream rule: a lane keeps `in_valid` and `in_data` stable until its transfer. The block does not check this.
- Output lane follows the same rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `select_lines` are stable.

## Timing
- Reset values, applied on the first edge with `rst`=1:
  - `out_valid`=0, `out_data`=0, `select_lines`=2'b00.
  - `last_grant`=2'b11, so lane 0 has first priority.
- While `rst`=1, `in_ready`=4'b0000 and no transfer takes place.
- Reset mid-operation: any held word is discarded without being delivered. A word offered in the reset cycle is not accepted.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` after edge N.
- Throughput: one word per cycle while `out_ready` stays 1, including back-to-back words from different lanes.
- Same-cycle drain and load while FULL with `out_ready`=1 and a valid lane: the held word leaves and the new word loads. No bubble.
- Stall: while FULL with `out_ready`=0, `in_ready`=0 and `last_grant` is frozen.
- Wrap-around: a grant to lane 3 sets `last_grant`=3, so lane 0 has priority next.
- All lanes valid continuously with `out_ready`=1: the output sequence is 0,1,2,3,0,...

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `in_valid`=4'b1111.
  - During reset: `in_ready`=0.
  - After the edge: `out_valid`=0, `out_data`=0, `select_lines`=00.
  - First cycle after release: `in_ready`=4'b0001.
- **Single lane:** lane 2 only, `in_data` lane 2 = 8'hA5, `out_ready`=1.
  - Same cycle: `in_ready`=4'b0100.
  - Next cycle: `out_valid`=1, `out_data`=8'hA5, `select_lines`=10.
- **Full contention:** all lanes valid with words 8'h10, 8'h11, 8'h12, 8'h13, `out_ready`=1, for 8 cycles.
  - `select_lines` sequence: 00,01,10,11,00,01,10,11.
  - `out_data` matches the source lane each cycle.
  - `out_valid` stays 1 with no gaps.
- **Backpressure:** output FULL with 8'h11 from lane 1, `out_ready`=0 for 3 cycles, lanes 0 and 3 valid.
  - During the stall: outputs frozen, `in_ready`=0.
  - Release `out_ready`=1: lane 3 is accepted next (order after 1 is 2,3,0), then lane 0.
- **Sparse rotation:** single words from lane 3, then lane 0, then lane 3, with idle cycles in between.
  - Each word is accepted immediately.
  - `last_grant` is unchanged across idle cycles.
- **Mid-operation reset:** output FULL, assert `rst` for 1 cycle.
  - After the edge: `out_valid`=0, `select_lines`=00, and the held word is never delivered.
  - Next grant with all lanes valid goes to lane 0.
